// File: rtl/bht_update_queue_pkg.sv
// Shared types and helpers for the branch-history-table update queue.
// Holds the core configuration record, the update/entry structs and the default hazard gap.
package bht_update_queue_pkg;

  localparam int unsigned BP_VLEN = 32;

  typedef struct packed {
    int unsigned VLEN;
    logic        DebugEn;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: BP_VLEN, DebugEn: 1'b1};

  typedef struct packed {
    logic               valid;
    logic [BP_VLEN-1:0] pc;
    logic               taken;
  } bht_update_t;

  typedef struct packed {
    logic [BP_VLEN-1:0] pc;
    logic               taken;
  } bp_queue_entry_t;

  localparam int unsigned BHT_HAZARD_GAP_DEFAULT = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bht_update_queue_hazard_window.sv
// Sliding window of recently issued predictor row indices; flags a head index that
// would read a row whose read-modify-write is still in flight.
module bht_hazard_window #(
  parameter int unsigned INDEX_BITS = 9,
  parameter int unsigned HAZARD_GAP = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  shift_vld_i,
  input  logic [INDEX_BITS-1:0] shift_idx_i,
  input  logic                  flush_i,
  input  logic [INDEX_BITS-1:0] cmp_idx_i,
  output logic                  hit_o
);

  logic [HAZARD_GAP-1:0]                 vld_q, vld_d;
  logic [HAZARD_GAP-1:0][INDEX_BITS-1:0] idx_q, idx_d;

  always_comb begin
    vld_d    = '0;
    idx_d    = idx_q;
    vld_d[0] = shift_vld_i;
    idx_d[0] = shift_idx_i;
    for (int i = 1; i < HAZARD_GAP; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    if (flush_i) vld_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Index slots are pure data; only the valid bits need a defined reset value.
  always_ff @(posedge clk_i) begin
    idx_q <= idx_d;
  end

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < HAZARD_GAP; i++) begin
      if (vld_q[i] && (idx_q[i] == cmp_idx_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/bht_update_queue.sv
// In-order ring buffer decoupling branch resolution from the BHT update port,
// spacing same-row updates so the synchronous-RAM predictor never reads stale state.
module bht_update_queue
  import bht_update_queue_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg      = cva6_cfg_empty,
  parameter type         bht_update_t = bht_update_queue_pkg::bht_update_t,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned INDEX_LSB    = 1,
  parameter int unsigned INDEX_BITS   = 9,
  parameter int unsigned HAZARD_GAP   = BHT_HAZARD_GAP_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  bht_update_t                resolve_i,
  output logic                       resolve_ready_o,
  output bht_update_t                bht_update_o,
  input  logic                       bht_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  bp_queue_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [7:0]         drop_q, drop_d;

  bp_queue_entry_t    head;
  logic [INDEX_BITS-1:0] head_idx;
  logic               debug_stall;
  logic               empty;
  logic               hazard;
  logic               issue_vld;
  logic               pop;
  logic               push_req;
  logic               accept;
  logic               push;
  logic               drop;

  assign debug_stall = CVA6Cfg.DebugEn && debug_mode_i;
  assign empty       = (occ_q == '0);
  assign head        = mem_q[rd_ptr_q];
  assign head_idx    = head.pc[INDEX_LSB +: INDEX_BITS];

  assign issue_vld   = !empty && !hazard && !debug_stall;
  assign pop         = issue_vld && bht_ready_i;

  // A full queue can still take a new entry when the head leaves in the same cycle.
  assign push_req    = resolve_i.valid && !flush_bp_i && !debug_stall;
  assign accept      = (occ_q < OCC_W'(DEPTH)) || pop;
  assign push        = push_req && accept;
  assign drop        = push_req && !accept;

  bht_hazard_window #(
    .INDEX_BITS (INDEX_BITS),
    .HAZARD_GAP (HAZARD_GAP)
  ) i_hazard_window (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .shift_vld_i (pop),
    .shift_idx_i (head_idx),
    .flush_i     (flush_bp_i),
    .cmp_idx_i   (head_idx),
    .hit_o       (hazard)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (pop && !push) occ_d = occ_q - OCC_W'(1);
    if (drop) drop_d = sat_inc8(drop_q);
    // Flush empties the queue; a concurrent pop was still seen by the predictor.
    if (flush_bp_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q].pc    <= resolve_i.pc;
      mem_q[wr_ptr_q].taken <= resolve_i.taken;
    end
  end

  always_comb begin
    bht_update_o = '0;
    if (issue_vld) begin
      bht_update_o.valid = 1'b1;
      bht_update_o.pc    = head.pc;
      bht_update_o.taken = head.taken;
    end
  end

  assign resolve_ready_o = accept;
  assign occupancy_o     = occ_q;
  assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed, table-driven bench for bht_update_queue (DEPTH=4, INDEX_LSB=1, HAZARD_GAP=2).
module tb_bht_update_queue;
  import bht_update_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_bp;
  logic        debug_mode;
  bht_update_t resolve;
  logic        resolve_ready;
  bht_update_t bht_update;
  logic        bht_ready;
  logic [2:0]  occupancy;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  bht_update_queue dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_bp_i      (flush_bp),
    .debug_mode_i    (debug_mode),
    .resolve_i       (resolve),
    .resolve_ready_o (resolve_ready),
    .bht_update_o    (bht_update),
    .bht_ready_i     (bht_ready),
    .occupancy_o     (occupancy),
    .drop_cnt_o      (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        tk;
    logic        rdy;
    logic        dbg;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    logic        etk;
    logic [2:0]  eocc;
    logic [7:0]  edrop;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [31:0] pc, input logic tk,
                              input logic rdy, input logic dbg, input logic fl,
                              input logic ev, input logic [31:0] epc, input logic etk,
                              input logic [2:0] eocc, input logic [7:0] edrop, input logic err);
    vec_t r;
    r.v = v; r.pc = pc; r.tk = tk; r.rdy = rdy; r.dbg = dbg; r.fl = fl;
    r.ev = ev; r.epc = epc; r.etk = etk; r.eocc = eocc; r.edrop = edrop; r.err = err;
    vecs.push_back(r);
  endfunction

  function automatic logic [45:0] observed();
    return {bht_update.valid, bht_update.pc, bht_update.taken, occupancy, drop_cnt, resolve_ready};
  endfunction

  function automatic logic [45:0] expect_of(input logic ev, input logic [31:0] epc, input logic etk,
                                            input logic [2:0] eocc, input logic [7:0] edrop,
                                            input logic err);
    return {ev, epc, etk, eocc, edrop, err};
  endfunction

  task automatic check(input string name, input logic [45:0] got, input logic [45:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got vld=%b pc=%h tk=%b occ=%0d drop=%0d rr=%b want vld=%b pc=%h tk=%b occ=%0d drop=%0d rr=%b",
               name, got[45], got[44:13], got[12], got[11:9], got[8:1], got[0],
               exp[45], exp[44:13], exp[12], exp[11:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic rdy, input logic dbg, input logic fl);
    resolve.valid = v;
    resolve.pc    = pc;
    resolve.taken = tk;
    bht_ready     = rdy;
    debug_mode    = dbg;
    flush_bp      = fl;
  endtask

  initial begin
    //   v  pc        tk rdy dbg fl | ev epc       etk occ drop rr
    // single push, issue one cycle later
    add(1, 32'h100, 1, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h100, 1, 1, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    // different indices issue back to back
    add(1, 32'h100, 0, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    add(1, 32'h104, 1, 1, 0, 0,   1, 32'h100, 0, 1, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h104, 1, 1, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    // same index spaced by HAZARD_GAP+1, younger entry blocked behind it
    add(1, 32'h100, 1, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    add(1, 32'h100, 0, 1, 0, 0,   1, 32'h100, 1, 1, 0, 1);
    add(1, 32'h200, 1, 1, 0, 0,   0, 32'h0,   0, 1, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 2, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h100, 0, 2, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h200, 1, 1, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    // overflow: six pushes into four entries, then drain in order
    add(1, 32'h100, 1, 0, 0, 0,   0, 32'h0,   0, 0, 0, 1);
    add(1, 32'h104, 0, 0, 0, 0,   1, 32'h100, 1, 1, 0, 1);
    add(1, 32'h108, 1, 0, 0, 0,   1, 32'h100, 1, 2, 0, 1);
    add(1, 32'h10C, 0, 0, 0, 0,   1, 32'h100, 1, 3, 0, 1);
    add(1, 32'h110, 1, 0, 0, 0,   1, 32'h100, 1, 4, 0, 0);
    add(1, 32'h114, 0, 0, 0, 0,   1, 32'h100, 1, 4, 1, 0);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h100, 1, 4, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h104, 0, 3, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h108, 1, 2, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h10C, 0, 1, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 2, 1);
    // debug mode freezes push and issue
    add(1, 32'h120, 1, 0, 0, 0,   0, 32'h0,   0, 0, 2, 1);
    add(1, 32'h124, 0, 0, 0, 0,   1, 32'h120, 1, 1, 2, 1);
    add(1, 32'h128, 1, 0, 0, 0,   1, 32'h120, 1, 2, 2, 1);
    for (int i = 0; i < 5; i++)
      add(1, 32'h130, 1, 1, 1, 0, 0, 32'h0,   0, 3, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h120, 1, 3, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h124, 0, 2, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h128, 1, 1, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 2, 1);
    // flush with a same-cycle push
    add(1, 32'h140, 1, 0, 0, 0,   0, 32'h0,   0, 0, 2, 1);
    add(1, 32'h144, 0, 0, 0, 0,   1, 32'h140, 1, 1, 2, 1);
    add(1, 32'h148, 1, 0, 0, 1,   1, 32'h140, 1, 2, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 2, 1);
    // flush with a same-cycle pop clears the hazard window
    add(1, 32'h100, 1, 1, 0, 0,   0, 32'h0,   0, 0, 2, 1);
    add(1, 32'h180, 1, 1, 0, 1,   1, 32'h100, 1, 1, 2, 1);
    add(1, 32'h100, 0, 1, 0, 0,   0, 32'h0,   0, 0, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   1, 32'h100, 0, 1, 2, 1);
    add(0, 32'h0,   0, 1, 0, 0,   0, 32'h0,   0, 0, 2, 1);

    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0);
    #2;
    check("reset", observed(), expect_of(0, 32'h0, 0, 0, 8'd0, 1));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].tk, vecs[i].rdy, vecs[i].dbg, vecs[i].fl);
      @(negedge clk);
      check($sformatf("row%0d", i), observed(),
            expect_of(vecs[i].ev, vecs[i].epc, vecs[i].etk, vecs[i].eocc, vecs[i].edrop, vecs[i].err));
      @(posedge clk);
      #1;
    end

    // asynchronous reset while entries are draining
    drive(1, 32'h150, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 32'h154, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 32'h158, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 32'h0, 0, 1, 0, 0);
    @(posedge clk); #1;
    check("pre_rst", observed(), expect_of(1, 32'h154, 0, 2, 8'd2, 1));
    #1 rst = 1'b1;
    #1;
    check("mid_rst", observed(), expect_of(0, 32'h0, 0, 0, 8'd0, 1));
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 32'h160, 1, 1, 0, 0);
    @(negedge clk);
    check("post_rst_push", observed(), expect_of(0, 32'h0, 0, 0, 8'd0, 1));
    @(posedge clk); #1;
    drive(0, 32'h0, 0, 1, 0, 0);
    @(negedge clk);
    check("post_rst_issue", observed(), expect_of(1, 32'h160, 1, 1, 8'd0, 1));
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
